// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 definitions for the fetch, decode and PC logic.
//               Holds the instruction-code encoding and the default address
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam int ADDR_W = 64;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack. The pointer addresses the
//               current top entry; a push pre-increments the pointer and
//               writes there, so when full the oldest entry is overwritten.
//               The count saturates at DEPTH. Restore reloads pointer and
//               count only; entry contents are left as they are.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_push/i_push_data - push a return address
//               i_pop              - pop (ignored when empty)
//               i_restore/_ptr/_cnt- reload pointer and count (highest prio)
//               o_top, o_ptr, o_cnt- top entry, pointer, occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
    import y86_pkg::*;
#(
    parameter  int ADDR_W = 64,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_restore,
    input  logic [PTR_W-1:0]  i_restore_ptr,
    input  logic [PTR_W:0]    i_restore_cnt,
    output logic [ADDR_W-1:0] o_top,
    output logic [PTR_W-1:0]  o_ptr,
    output logic [PTR_W:0]    o_cnt
);

    localparam logic [PTR_W:0] c_cnt_max = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W:0]    r_cnt;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_ptr_dec;

    // DEPTH is a power of two, so natural wrap of the pointer is the modulo.
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_restore) begin
            r_ptr <= i_restore_ptr;
            r_cnt <= i_restore_cnt;
        end else if (i_push) begin
            r_ptr <= w_ptr_inc;
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_pop && (r_cnt != '0)) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_restore) begin
            r_mem[w_ptr_inc] <= i_push_data;
        end
    end

    assign o_top = r_mem[r_ptr];
    assign o_ptr = r_ptr;
    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pc_predict_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_predict_ras
// Description : Fetch-stage PC register and next-PC predictor for the
//               pipelined Y86-64 core. jXX predicted taken, call goes to
//               valC and pushes valP, ret predicted from the RAS. Applies
//               ret mispredicts from memory (highest priority) and jXX
//               mispredicts from execute (with RAS pointer/count restore).
// Ports       : clk, rst_n                 - clock, async active-low reset
//               stall                      - hold PC and RAS
//               f_valid/f_icode/f_valC/f_valP - fetched instruction fields
//               ex_jxx/ex_cnd/ex_valP/ex_ras_ptr/ex_ras_cnt - jXX resolution
//               m_ret/m_valM/m_pred        - ret verification
//               f_pc, f_pred_pc            - current and predicted PC
//               f_ras_ptr, f_ras_cnt       - RAS snapshot for the pipe
//               redirect, halted           - correction / halt status
// Revision    : 1.0 - initial release
// ============================================================================
module pc_predict_ras
#(
    parameter  int                ADDR_W    = y86_pkg::ADDR_W,
    parameter  int                RAS_DEPTH = 8,
    parameter  logic [ADDR_W-1:0] RESET_PC  = '0,
    localparam int                PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic              ex_jxx,
    input  logic              ex_cnd,
    input  logic [ADDR_W-1:0] ex_valP,
    input  logic [PTR_W-1:0]  ex_ras_ptr,
    input  logic [PTR_W:0]    ex_ras_cnt,
    input  logic              m_ret,
    input  logic [ADDR_W-1:0] m_valM,
    input  logic [ADDR_W-1:0] m_pred,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] f_pred_pc,
    output logic [PTR_W-1:0]  f_ras_ptr,
    output logic [PTR_W:0]    f_ras_cnt,
    output logic              redirect,
    output logic              halted
);

    import y86_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic [ADDR_W-1:0] w_ras_top;
    logic [PTR_W-1:0]  w_ras_ptr;
    logic [PTR_W:0]    w_ras_cnt;
    logic [ADDR_W-1:0] w_pred_pc;
    logic              w_ret_mis;
    logic              w_jxx_mis;
    logic              w_redirect;
    logic              w_advance;
    logic              w_push;
    logic              w_pop;
    logic              w_restore;

    assign w_ret_mis  = m_ret && (m_valM != m_pred);
    assign w_jxx_mis  = ex_jxx && !ex_cnd;
    assign w_redirect = w_ret_mis || w_jxx_mis;

    // The fetch only takes effect when nothing younger is being flushed,
    // so a wrong-path instruction in a redirect cycle never touches the RAS.
    assign w_advance  = f_valid && !w_redirect && !stall && !r_halted;
    assign w_push     = w_advance && (f_icode == I_CALL);
    assign w_pop      = w_advance && (f_icode == I_RET) && (w_ras_cnt != '0);
    // A ret mispredict outranks the jXX, and its own flush discards the
    // jXX snapshot as well.
    assign w_restore  = w_jxx_mis && !w_ret_mis;

    always_comb begin
        w_pred_pc = f_valP;
        case (icode_e'(f_icode))
            I_JXX,
            I_CALL:  w_pred_pc = f_valC;
            I_RET:   w_pred_pc = (w_ras_cnt != '0) ? w_ras_top : f_valP;
            default: w_pred_pc = f_valP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_ret_mis) begin
            r_pc <= m_valM;
        end else if (w_jxx_mis) begin
            r_pc <= ex_valP;
        end else if (w_advance) begin
            r_pc <= w_pred_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (w_redirect) begin
            r_halted <= 1'b0;
        end else if (w_advance && (f_icode == I_HALT)) begin
            r_halted <= 1'b1;
        end
    end

    ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_data   (f_valP),
        .i_pop         (w_pop),
        .i_restore     (w_restore),
        .i_restore_ptr (ex_ras_ptr),
        .i_restore_cnt (ex_ras_cnt),
        .o_top         (w_ras_top),
        .o_ptr         (w_ras_ptr),
        .o_cnt         (w_ras_cnt)
    );

    assign f_pc      = r_pc;
    assign f_pred_pc = w_pred_pc;
    assign f_ras_ptr = w_ras_ptr;
    assign f_ras_cnt = w_ras_cnt;
    assign redirect  = w_redirect;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_ras.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_predict_ras
// Description : Self-checking bench for pc_predict_ras (RAS_DEPTH=4,
//               RESET_PC=0x100). Directed scenarios plus randomized traffic
//               checked against a behavioural model of the fetch PC and
//               return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_predict_ras;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        f_valid;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        ex_jxx;
    logic        ex_cnd;
    logic [63:0] ex_valP;
    logic [1:0]  ex_ras_ptr;
    logic [2:0]  ex_ras_cnt;
    logic        m_ret;
    logic [63:0] m_valM;
    logic [63:0] m_pred;
    logic [63:0] f_pc;
    logic [63:0] f_pred_pc;
    logic [1:0]  f_ras_ptr;
    logic [2:0]  f_ras_cnt;
    logic        redirect;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [63:0] mdl_pc;
    int          mdl_ptr;
    int          mdl_cnt;
    bit          mdl_halted;
    logic [63:0] mdl_stk [D];

    pc_predict_ras #(
        .ADDR_W    (64),
        .RAS_DEPTH (D),
        .RESET_PC  (64'h100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .f_valid    (f_valid),
        .f_icode    (f_icode),
        .f_valC     (f_valC),
        .f_valP     (f_valP),
        .ex_jxx     (ex_jxx),
        .ex_cnd     (ex_cnd),
        .ex_valP    (ex_valP),
        .ex_ras_ptr (ex_ras_ptr),
        .ex_ras_cnt (ex_ras_cnt),
        .m_ret      (m_ret),
        .m_valM     (m_valM),
        .m_pred     (m_pred),
        .f_pc       (f_pc),
        .f_pred_pc  (f_pred_pc),
        .f_ras_ptr  (f_ras_ptr),
        .f_ras_cnt  (f_ras_cnt),
        .redirect   (redirect),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [63:0] mdl_pred();
        if (f_icode == 4'd7 || f_icode == 4'd8) return f_valC;
        if (f_icode == 4'd9 && mdl_cnt > 0) return mdl_stk[mdl_ptr];
        return f_valP;
    endfunction

    function automatic bit mdl_redirect();
        return (m_ret && (m_valM != m_pred)) || (ex_jxx && !ex_cnd);
    endfunction

    task automatic mdl_reset();
        mdl_pc = 64'h100; mdl_ptr = 0; mdl_cnt = 0; mdl_halted = 0;
        for (int i = 0; i < D; i++) mdl_stk[i] = '0;
    endtask

    task automatic mdl_step();
        logic [63:0] p;
        p = mdl_pred();
        if (m_ret && (m_valM != m_pred)) begin
            mdl_pc = m_valM; mdl_halted = 0;
        end else if (ex_jxx && !ex_cnd) begin
            mdl_pc = ex_valP; mdl_ptr = ex_ras_ptr; mdl_cnt = ex_ras_cnt; mdl_halted = 0;
        end else if (!stall && !mdl_halted && f_valid) begin
            mdl_pc = p;
            if (f_icode == 4'd0) mdl_halted = 1;
            if (f_icode == 4'd8) begin
                mdl_ptr = (mdl_ptr + 1) % D;
                mdl_stk[mdl_ptr] = f_valP;
                if (mdl_cnt < D) mdl_cnt++;
            end else if (f_icode == 4'd9 && mdl_cnt > 0) begin
                mdl_ptr = (mdl_ptr + D - 1) % D;
                mdl_cnt--;
            end
        end
    endtask

    // Advance one clock with the model following; leaves time at edge+1.
    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; f_valid = 0; f_icode = 4'd1; f_valC = '0; f_valP = '0;
        ex_jxx = 0; ex_cnd = 0; ex_valP = '0; ex_ras_ptr = '0; ex_ras_cnt = '0;
        m_ret = 0; m_valM = '0; m_pred = '0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        f_valid = 1; f_icode = ic; f_valC = vc; f_valP = vp;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 0;
        mdl_reset();
        #2;
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        mdl_reset();
        #2;
        n_checks++; if (f_pc !== 64'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", f_pc, 64'h100); end
        n_checks++; if (f_ras_ptr !== 2'd0 || f_ras_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_ras: got ptr %0d cnt %0d expected 0 0", f_ras_ptr, f_ras_cnt); end
        n_checks++; if (halted !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted %b redirect %b expected 0 0", halted, redirect); end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_nop();
        fetch(4'd1, 64'h0, 64'h101);
        #1;
        n_checks++; if (f_pred_pc !== 64'h101) begin n_fail++; $display("FAIL nop_pred: got %h expected %h", f_pred_pc, 64'h101); end
        tick();
        n_checks++; if (f_pc !== 64'h101) begin n_fail++; $display("FAIL nop_pc: got %h expected %h", f_pc, 64'h101); end
    endtask

    task automatic test_call_ret();
        fetch(4'd8, 64'h400, 64'h10A);
        tick();
        n_checks++; if (f_pc !== 64'h400 || f_ras_cnt !== 3'd1) begin n_fail++; $display("FAIL call: got pc %h cnt %0d expected 400 1", f_pc, f_ras_cnt); end
        fetch(4'd6, 64'h0, 64'h402);
        tick();
        fetch(4'd9, 64'h0, 64'h403);
        #1;
        n_checks++; if (f_pred_pc !== 64'h10A) begin n_fail++; $display("FAIL ret_pred: got %h expected %h", f_pred_pc, 64'h10A); end
        tick();
        n_checks++; if (f_pc !== 64'h10A || f_ras_cnt !== 3'd0) begin n_fail++; $display("FAIL ret_pop: got pc %h cnt %0d expected 10a 0", f_pc, f_ras_cnt); end
    endtask

    task automatic test_jxx_restore();
        fetch(4'd8, 64'h110, 64'h115);      // ptr 1 cnt 1
        tick();
        fetch(4'd7, 64'h200, 64'h120);
        #1;
        n_checks++; if (f_pred_pc !== 64'h200 || f_ras_ptr !== 2'd1 || f_ras_cnt !== 3'd1) begin n_fail++; $display("FAIL jxx_pred: got %h ptr %0d cnt %0d expected 200 1 1", f_pred_pc, f_ras_ptr, f_ras_cnt); end
        tick();
        fetch(4'd8, 64'h300, 64'h209);
        tick();
        fetch(4'd8, 64'h500, 64'h309);      // ptr 3 cnt 3
        tick();
        stall = 1; fetch(4'd9, 64'h0, 64'h501);
        ex_jxx = 1; ex_cnd = 0; ex_valP = 64'h120; ex_ras_ptr = 2'd1; ex_ras_cnt = 3'd1;
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL jxx_redirect: got %b expected 1", redirect); end
        tick();
        drive_idle();
        n_checks++; if (f_pc !== 64'h120 || f_ras_ptr !== 2'd1 || f_ras_cnt !== 3'd1) begin n_fail++; $display("FAIL jxx_restore: got pc %h ptr %0d cnt %0d expected 120 1 1", f_pc, f_ras_ptr, f_ras_cnt); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            fetch(4'd8, 64'h1000 + 64'(i) * 64'h100, 64'h2000 + 64'(i) * 64'h10);
            tick();
        end
        n_checks++; if (f_ras_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 4", f_ras_cnt); end
        for (int j = 0; j < 5; j++) begin
            fetch(4'd9, 64'h0, 64'h3000 + 64'(j));
            exp = (j < 4) ? 64'h2000 + 64'(4 - j) * 64'h10 : 64'h3000 + 64'(j);
            #1;
            n_checks++; if (f_pred_pc !== exp) begin n_fail++; $display("FAIL ovf_ret%0d: got %h expected %h", j, f_pred_pc, exp); end
            tick();
        end
        drive_idle();
        m_ret = 1; m_valM = 64'h777; m_pred = 64'h3004;
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL ovf_redirect: got %b expected 1", redirect); end
        tick();
        drive_idle();
        n_checks++; if (f_pc !== 64'h777 || f_ras_cnt !== 3'd0) begin n_fail++; $display("FAIL ovf_fix: got pc %h cnt %0d expected 777 0", f_pc, f_ras_cnt); end
    endtask

    task automatic test_simultaneous();
        // RAS is at ptr 1, cnt 0 after the overflow scenario.
        m_ret = 1; m_valM = 64'h300; m_pred = 64'h999;
        ex_jxx = 1; ex_cnd = 0; ex_valP = 64'h150; ex_ras_ptr = 2'd3; ex_ras_cnt = 3'd2;
        fetch(4'd8, 64'h880, 64'h888);
        tick();
        drive_idle();
        n_checks++; if (f_pc !== 64'h300) begin n_fail++; $display("FAIL simul_pc: got %h expected %h", f_pc, 64'h300); end
        n_checks++; if (f_ras_ptr !== 2'd1 || f_ras_cnt !== 3'd0) begin n_fail++; $display("FAIL simul_ras: got ptr %0d cnt %0d expected 1 0", f_ras_ptr, f_ras_cnt); end
    endtask

    task automatic test_halt();
        fetch(4'd0, 64'h0, 64'h301);
        tick();
        n_checks++; if (halted !== 1'b1 || f_pc !== 64'h301) begin n_fail++; $display("FAIL halt_set: got halted %b pc %h expected 1 301", halted, f_pc); end
        fetch(4'd1, 64'h0, 64'h999);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (f_pc !== 64'h301 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold%0d: got pc %h halted %b expected 301 1", k, f_pc, halted); end
        end
        ex_jxx = 1; ex_cnd = 0; ex_valP = 64'h180; ex_ras_ptr = 2'd1; ex_ras_cnt = 3'd0;
        tick();
        drive_idle();
        n_checks++; if (halted !== 1'b0 || f_pc !== 64'h180) begin n_fail++; $display("FAIL halt_clear: got halted %b pc %h expected 0 180", halted, f_pc); end
    endtask

    task automatic test_async_reset();
        fetch(4'd8, 64'h620, 64'h610);
        tick();
        stall = 1; ex_jxx = 1; ex_cnd = 0; ex_valP = 64'h55;
        #2;
        rst_n = 0;
        mdl_reset();
        #1;
        n_checks++; if (f_pc !== 64'h100 || f_ras_cnt !== 3'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc %h cnt %0d halted %b expected 100 0 0", f_pc, f_ras_cnt, halted); end
        drive_idle();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_random();
        logic [63:0] ep;
        bit          er;
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            stall = ($urandom_range(0, 4) == 0);
            f_valid = ($urandom_range(0, 5) != 0);
            f_icode = 4'($urandom_range(0, 11));
            if (f_icode == 4'd0 && $urandom_range(0, 2) != 0) f_icode = 4'd9;
            f_valC = {$urandom, $urandom};
            f_valP = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin
                ex_jxx = 1; ex_cnd = $urandom_range(0, 1) == 1;
                ex_valP = {$urandom, $urandom};
                ex_ras_ptr = 2'($urandom_range(0, 3));
                ex_ras_cnt = 3'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 5) == 0) begin
                m_ret = 1; m_pred = {$urandom, $urandom};
                m_valM = ($urandom_range(0, 1) == 1) ? m_pred : {$urandom, $urandom};
            end
            #1;
            ep = mdl_pred();
            er = mdl_redirect();
            n_checks++; if (f_pred_pc !== ep) begin n_fail++; $display("FAIL rnd_pred[%0d]: got %h expected %h", n, f_pred_pc, ep); end
            n_checks++; if (redirect !== er) begin n_fail++; $display("FAIL rnd_redirect[%0d]: got %b expected %b", n, redirect, er); end
            tick();
            n_checks++; if (f_pc !== mdl_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, f_pc, mdl_pc); end
            n_checks++; if (f_ras_ptr !== mdl_ptr[1:0] || f_ras_cnt !== mdl_cnt[2:0]) begin n_fail++; $display("FAIL rnd_ras[%0d]: got ptr %0d cnt %0d expected %0d %0d", n, f_ras_ptr, f_ras_cnt, mdl_ptr, mdl_cnt); end
            n_checks++; if (halted !== mdl_halted) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %b expected %b", n, halted, mdl_halted); end
        end
    endtask

    initial begin
        rst_n = 1;
        drive_idle();
        mdl_reset();
        #1;
        test_reset();
        test_nop();
        test_call_ret();
        test_jxx_restore();
        test_overflow();
        test_simultaneous();
        test_halt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
